// File: rtl/majority_filter_bank_if.sv
// Signal bundle for majority_filter_bank: shared sample strobe, raw inputs,
// and the filtered level plus edge pulses per channel.
interface majority_filter_bank_if #(
    parameter int CHANNELS = 1
);
    logic                sampleEn;
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (output sampleEn, output in, input out, input rise, input fall);
    modport slave  (input sampleEn, input in, output out, output rise, output fall);
endinterface

// File: rtl/majority_filter_bank.sv
// Multi-channel majority/hysteresis deglitch filter with optional synchroniser.
// Optional post-transition decision holdoff is enabled by MAJ_FILTER_HOLDOFF_EN.
module majority_filter_bank #(
    parameter int CHANNELS    = 1,
    parameter int DEPTH       = 3,
    parameter int HI_THRESH   = DEPTH / 2 + 1,
    parameter int LO_THRESH   = DEPTH / 2,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_LEVEL = 1,
    parameter int HOLDOFF     = 0
) (
    input  logic                   clkIn,
    input  logic                   nResetIn,
    majority_filter_bank_if.slave  bus
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic           RST_BIT = (RESET_LEVEL != 0);
    localparam logic [CW-1:0]  CNT_RST = RST_BIT ? CW'(DEPTH) : {CW{1'b0}};
    localparam logic [CW-1:0]  HI_C    = CW'(HI_THRESH);
    localparam logic [CW-1:0]  LO_C    = CW'(LO_THRESH);

    logic [CHANNELS-1:0] w_out;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic             w_s;
        logic             w_old;
        logic [DEPTH-1:0] r_win;
        logic [CW-1:0]    r_cnt;
        logic [CW-1:0]    w_cnt_next;
        logic             r_out;
        logic             r_rise;
        logic             r_fall;
        logic             w_dec;
        logic             w_frozen;
        logic             w_change;

        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = bus.in[ch];
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Synchroniser chain, shifts every clock independent of the strobe
            always_ff @(posedge clkIn or negedge nResetIn) begin
                if (!nResetIn) begin
                    r_sync <= {SYNC_STAGES{RST_BIT}};
                end else begin
                    r_sync <= (r_sync << 1) | SYNC_STAGES'(bus.in[ch]);
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end

        assign w_old      = r_win[DEPTH-1];
        assign w_cnt_next = r_cnt + CW'(w_s) - CW'(w_old);

        // Hysteresis decision taken on the post-shift count, so no extra latency
        always_comb begin
            w_dec = r_out;
            if (w_cnt_next >= HI_C) begin
                w_dec = 1'b1;
            end else if (w_cnt_next <= LO_C) begin
                w_dec = 1'b0;
            end else begin
                w_dec = r_out;
            end
        end

`ifdef MAJ_FILTER_HOLDOFF_EN
        localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
        logic [HW-1:0] r_hold;

        // Decision resumes on the same sample that brings the counter to zero
        assign w_frozen = (r_hold > HW'(1));

        // Holdoff counter: reload on a transition, count down per strobe
        always_ff @(posedge clkIn or negedge nResetIn) begin
            if (!nResetIn) begin
                r_hold <= {HW{1'b0}};
            end else if (bus.sampleEn) begin
                if (w_change) begin
                    r_hold <= HW'(HOLDOFF);
                end else if (r_hold != {HW{1'b0}}) begin
                    r_hold <= r_hold - HW'(1);
                end else begin
                    r_hold <= r_hold;
                end
            end else begin
                r_hold <= r_hold;
            end
        end
`else
        assign w_frozen = 1'b0;
`endif

        assign w_change = !w_frozen && (w_dec != r_out);

        // Window, ones-count, filtered level and edge pulses
        always_ff @(posedge clkIn or negedge nResetIn) begin
            if (!nResetIn) begin
                r_win  <= {DEPTH{RST_BIT}};
                r_cnt  <= CNT_RST;
                r_out  <= RST_BIT;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (bus.sampleEn) begin
                r_win <= (r_win << 1) | DEPTH'(w_s);
                r_cnt <= w_cnt_next;
                if (w_change) begin
                    r_out  <= w_dec;
                    r_rise <= w_dec;
                    r_fall <= !w_dec;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end

        assign w_out[ch]  = r_out;
        assign w_rise[ch] = r_rise;
        assign w_fall[ch] = r_fall;
    end

    assign bus.out  = w_out;
    assign bus.rise = w_rise;
    assign bus.fall = w_fall;
endmodule

// File: tb/tb_majority_filter_bank.sv
// Directed bench for majority_filter_bank: several configurations instantiated
// side by side, each exercised by a linear sequence of hand-computed steps.
module tb_majority_filter_bank;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n;
    logic rst_n;
    logic rst4_n;
    int   n_vec = 0;
    int   n_err = 0;

    majority_filter_bank_if #(.CHANNELS(1)) if0 ();
    majority_filter_bank_if #(.CHANNELS(1)) if1 ();
    majority_filter_bank_if #(.CHANNELS(1)) if2 ();
    majority_filter_bank_if #(.CHANNELS(1)) if3 ();
    majority_filter_bank_if #(.CHANNELS(4)) if4 ();
    majority_filter_bank_if #(.CHANNELS(1)) if5 ();

    // DEPTH=3, two-stage synchroniser, idle-high
    majority_filter_bank #(.CHANNELS(1), .DEPTH(3), .SYNC_STAGES(2)) u0 (
        .clkIn(clk), .nResetIn(rst0_n), .bus(if0.slave));
    // DEPTH=3, no synchroniser
    majority_filter_bank #(.CHANNELS(1), .DEPTH(3), .SYNC_STAGES(0)) u1 (
        .clkIn(clk), .nResetIn(rst_n), .bus(if1.slave));
    // DEPTH=7 with a wide dead band, idle-low
    majority_filter_bank #(.CHANNELS(1), .DEPTH(7), .HI_THRESH(6), .LO_THRESH(1),
                           .SYNC_STAGES(0), .RESET_LEVEL(0)) u2 (
        .clkIn(clk), .nResetIn(rst_n), .bus(if2.slave));
    // DEPTH=5, strobed sampling
    majority_filter_bank #(.CHANNELS(1), .DEPTH(5), .SYNC_STAGES(0)) u3 (
        .clkIn(clk), .nResetIn(rst_n), .bus(if3.slave));
    // Four channels, DEPTH=3
    majority_filter_bank #(.CHANNELS(4), .DEPTH(3), .SYNC_STAGES(0)) u4 (
        .clkIn(clk), .nResetIn(rst4_n), .bus(if4.slave));
    // DEPTH=3 with HOLDOFF=4 (only active when the holdoff macro is set)
    majority_filter_bank #(.CHANNELS(1), .DEPTH(3), .SYNC_STAGES(0), .HOLDOFF(4)) u5 (
        .clkIn(clk), .nResetIn(rst_n), .bus(if5.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ho_out;
    logic [3:0] ho_rise;

    initial begin
        rst0_n = 1'b0; rst_n = 1'b0; rst4_n = 1'b0;
        if0.sampleEn = 1'b1; if0.in = 1'b0;
        if1.sampleEn = 1'b1; if1.in = 1'b1;
        if2.sampleEn = 1'b1; if2.in = 1'b0;
        if3.sampleEn = 1'b1; if3.in = 1'b1;
        if4.sampleEn = 1'b1; if4.in = 4'hF;
        if5.sampleEn = 1'b1; if5.in = 1'b1;

        // Reset values while reset is held with the clock running
        #12;
        chk("rst_out",  32'(if0.out),  32'd1);
        chk("rst_rise", 32'(if0.rise), 32'd0);
        chk("rst_fall", 32'(if0.fall), 32'd0);
        chk("rst_out_lvl0", 32'(if2.out), 32'd0);
        tick();
        tick();
        chk("rst_hold_out",  32'(if0.out),  32'd1);
        chk("rst_hold_fall", 32'(if0.fall), 32'd0);

        // Release: synced 0 reaches the window after two clocks, out falls on the 4th
        rst0_n = 1'b1; rst_n = 1'b1; rst4_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("sync_out_c%0d", c),  32'(if0.out),  (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("sync_fall_c%0d", c), 32'(if0.fall), (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("sync_rise_c%0d", c), 32'(if0.rise), 32'd0);
        end

        // Single-sample glitch is rejected
        if1.in = 1'b0; tick();
        chk("glitch_out",  32'(if1.out),  32'd1);
        chk("glitch_fall", 32'(if1.fall), 32'd0);
        if1.in = 1'b1;
        tick(); tick(); tick();
        chk("glitch_settle", 32'(if1.out), 32'd1);
        // Two consecutive zeros flip the output on the second sample
        if1.in = 1'b0; tick();
        chk("two0_s1_out", 32'(if1.out), 32'd1);
        tick();
        chk("two0_s2_out",  32'(if1.out),  32'd0);
        chk("two0_s2_fall", 32'(if1.fall), 32'd1);
        tick();
        chk("two0_s3_fall", 32'(if1.fall), 32'd0);
        chk("two0_s3_out",  32'(if1.out),  32'd0);

        // Dead band: alternating input never reaches HI_THRESH=6
        for (int i = 0; i < 20; i++) begin
            if2.in = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("alt_out_%0d", i),  32'(if2.out),  32'd0);
            chk($sformatf("alt_rise_%0d", i), 32'(if2.rise), 32'd0);
        end
        if2.in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("flush_out_%0d", i), 32'(if2.out), 32'd0);
        end
        if2.in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("ones_out_%0d", k),  32'(if2.out),  (k >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("ones_rise_%0d", k), 32'(if2.rise), (k == 6) ? 32'd1 : 32'd0);
        end

        // Strobe one clock in four: fall on the third strobe (clock 12)
        if3.in = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if3.sampleEn = (c % 4 == 0) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("strb_out_c%0d", c),  32'(if3.out),  (c < 12) ? 32'd1 : 32'd0);
            chk($sformatf("strb_fall_c%0d", c), 32'(if3.fall), (c == 12) ? 32'd1 : 32'd0);
            chk($sformatf("strb_rise_c%0d", c), 32'(if3.rise), 32'd0);
        end

        // Channel independence: step channel 2 only
        if4.in = 4'b1011; tick();
        chk("ch2_s1_out", 32'(if4.out), 32'hF);
        tick();
        chk("ch2_s2_out",  32'(if4.out),  32'hB);
        chk("ch2_s2_fall", 32'(if4.fall), 32'h4);
        chk("ch2_s2_rise", 32'(if4.rise), 32'h0);
        if4.in = 4'hF; tick();
        chk("ch2_r1_out",  32'(if4.out),  32'hB);
        chk("ch2_r1_fall", 32'(if4.fall), 32'h0);
        tick();
        chk("ch2_r2_out",  32'(if4.out),  32'hF);
        chk("ch2_r2_rise", 32'(if4.rise), 32'h4);
        tick(); tick();
        // Reset mid-transition at count 2 of 3
        if4.in = 4'b1011; tick();
        chk("mid_out", 32'(if4.out), 32'hF);
        rst4_n = 1'b0; #1;
        chk("mid_rst_out",  32'(if4.out),  32'hF);
        chk("mid_rst_fall", 32'(if4.fall), 32'h0);
        // Reset while a fall pulse is pending
        rst4_n = 1'b1; tick();
        tick();
        chk("pend_pulse", 32'(if4.fall), 32'h4);
        rst4_n = 1'b0; #1;
        chk("pend_rst_fall", 32'(if4.fall), 32'h0);
        chk("pend_rst_out",  32'(if4.out),  32'hF);
        if4.in = 4'hF; #2; rst4_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("post_rst_out_%0d", c),  32'(if4.out),  32'hF);
            chk($sformatf("post_rst_fall_%0d", c), 32'(if4.fall), 32'h0);
            chk($sformatf("post_rst_rise_%0d", c), 32'(if4.rise), 32'h0);
        end

        // Holdoff after a fall
        if5.in = 1'b0; tick(); tick();
        chk("ho_fall_out",   32'(if5.out),  32'd0);
        chk("ho_fall_pulse", 32'(if5.fall), 32'd1);
`ifdef MAJ_FILTER_HOLDOFF_EN
        ho_out  = 4'b1000;
        ho_rise = 4'b1000;
`else
        ho_out  = 4'b1110;
        ho_rise = 4'b0010;
`endif
        if5.in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("ho_out_%0d", k),  32'(if5.out),  32'(ho_out[k-1]));
            chk($sformatf("ho_rise_%0d", k), 32'(if5.rise), 32'(ho_rise[k-1]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/majority_filter_bank.md
Name: majority_filter_bank

Overview:
- Parametrised multi-channel majority/hysteresis deglitch filter for asynchronous serial and GPIO inputs (UART RX, buttons, strobes).
- Per channel: optional input synchroniser, DEPTH-sample sliding window sampled on a shared strobe, running ones-count, hysteresis decision, and registered rise/fall pulses.
- Sits between the pads and protocol receivers, generalising the fixed 3-tap always-sampling vote to N channels, any window and programmable thresholds.

Parameters:
- CHANNELS, 1, number of independent filtered inputs.
- DEPTH, 3, window length in samples; legal 2..31.
- HI_THRESH, DEPTH/2+1, output goes 1 when ones-count >= HI_THRESH.
- LO_THRESH, DEPTH/2, output goes 0 when ones-count <= LO_THRESH; requires 0 <= LO_THRESH < HI_THRESH <= DEPTH.
- SYNC_STAGES, 2, flip-flop synchroniser stages ahead of the window; 0..3, 0 = bypass.
- RESET_LEVEL, 1, reset value of window bits, synchroniser flops and out (1 = UART idle).
- HOLDOFF, 0, samples ignored after an output transition; used only with MAJ_FILTER_HOLDOFF_EN.

Ports:
- clkIn  input  1  system clock.
- nResetIn  input  1  asynchronous active-low reset.
- sampleEn  input  1  sample strobe; tie high to sample every clock.
- in  input  CHANNELS  raw asynchronous inputs.
- out  output  CHANNELS  filtered levels.
- rise  output  CHANNELS  one-clock pulse on out 0->1.
- fall  output  CHANNELS  one-clock pulse on out 1->0.

Behaviour:
- Reset (async assert, sync release on clkIn): synchroniser flops and window bits = RESET_LEVEL; count = DEPTH if RESET_LEVEL else 0; out = RESET_LEVEL; rise = fall = 0; holdoff counter = 0.
- Synchroniser shifts every clkIn regardless of sampleEn; synced input s lags in by SYNC_STAGES clocks.
- On clkIn with sampleEn=1, per channel:
  - window shifts in s; oldest bit drops.
  - count_next = count + s - oldest, exact, never outside 0..DEPTH; count width clog2(DEPTH+1).
  - decision on count_next: >= HI_THRESH -> out=1; <= LO_THRESH -> out=0; otherwise hold.
  - out, count and window update at the same edge; no extra decision latency.
- sampleEn=0: window, count and out hold; rise and fall forced 0.
- rise/fall registered at the edge where out changes; high for exactly one clkIn; never both high together.
- Default thresholds give a pure majority vote with no dead band. Even DEPTH with defaults: a tie holds.
- Step latency, sampleEn=1 continuous, from an in edge to out change: SYNC_STAGES + (HI_THRESH - current count) clocks for a rising step from a settled all-0 window. Fall is symmetric.
- Isolated glitch of fewer than (DEPTH - LO_THRESH) samples from a settled all-1 window leaves out unchanged.
- Reset mid-operation: all state returns to reset values immediately; pending pulses are cleared.
- Channels are fully independent; only sampleEn is shared.

Optional Feature:
- Macro: MAJ_FILTER_HOLDOFF_EN.
- Defined: per-channel counter loads HOLDOFF on each out transition and decrements on each sampleEn. While it is non-zero, the window and count keep updating but the decision is frozen, so out holds. When it reaches 0, the decision resumes on the current count.
- Undefined: no counter logic; HOLDOFF is ignored; behaviour is as above.

Test Plan:
- Reset with RESET_LEVEL=1, in=0, nResetIn low -> out=1, rise=fall=0 while in reset. Release with CHANNELS=1, DEPTH=3, SYNC=2, sampleEn=1 -> out falls 4 clocks after release and fall pulses exactly once.
- DEPTH=3, SYNC=0, settled 1, one-sample 0 glitch -> out stays 1, no fall. Two consecutive 0 samples -> out=0 at the 2nd sample edge, with a one-clock fall pulse.
- DEPTH=7, HI=6, LO=1, SYNC=0: alternate 1,0 for 20 samples from all-0 -> out stays 0. Then seven 1s -> out=1 at the 6th, single rise.
- sampleEn high one clock in four, DEPTH=5, SYNC=0, in steps 1->0 -> out falls on the 3rd strobe (12th clock). rise/fall stay 0 on non-strobe clocks.
- CHANNELS=4, step channel 2 only -> only out[2], rise[2] and fall[2] change. Assert nResetIn mid-transition with count=2 of 3 -> out=RESET_LEVEL immediately and no pulse after release until the input changes again.
- MAJ_FILTER_HOLDOFF_EN, HOLDOFF=4, DEPTH=3: after a fall, drive a clean 1 for 3 samples -> out stays 0. At the 4th sample out=1 with a rise pulse.
